if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage: owns the program counter, fetches one instruction word per request from instruction memory over a req/ack handshake, and presents `IR_out`/`PC_out` with a valid flag to the decode stage directly downstream. Honours the same `IsStall`/`IsFlush` controls as decode, accepts branch redirects, and stops fetching after delivering a `HALT`. Includes a one-entry skid buffer so a memory response arriving during a stall is never lost.

## Interface
- `WIDTH`, 32, datapath width; PC is a word address of `WIDTH-2` bits.
- `RESET_PC`, 0, word address fetched first after reset.

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Imem_req`  out  1  fetch request, level; held until `Imem_ack`.
- `Imem_addr`  out  WIDTH-2  word address; stable while `Imem_req`=1 and no ack.
- `Imem_data`  in  WIDTH  instruction word, valid when `Imem_ack`=1.
- `Imem_ack`  in  1  one-cycle response strobe; may assert in the same cycle as `Imem_req` (zero-wait memory).
- `IR_out`  out  WIDTH  instruction to decode; `NOP when invalid.
- `PC_out`  out  WIDTH-2  word address of `IR_out`.
- `IR_valid`  out  1  `IR_out` is a real fetched instruction.
- `IsStall`  in  1  decode not accepting; hold outputs.
- `IsFlush`  in  1  squash output and any in-flight fetch.
- `Br_taken`  in  1  redirect; implies flush.
- `Br_tgt`  in  WIDTH-2  redirect target.
- `Halted`  out  1  fetch stopped after `HALT`.

## Operation
- Registers: `pc`, `IR_out`, `PC_out`, `IR_valid`, skid buffer (`buf_ir`, `buf_pc`), `drop` flag, `stale_addr`, state ∈ {FETCH, HOLD, HALTED}.
- `Imem_req` = (state==FETCH) or `drop`. `Imem_addr` = `drop` ? `stale_addr` : `pc`.
- Priority at each edge: `rst` > redirect/flush > stall > normal.
- Reset: `pc`=RESET_PC, `IR_out`=`NOP, `PC_out`=0, `IR_valid`=0, `Halted`=0, `drop`=0, state FETCH.
- Flush (`IsFlush` or `Br_taken`): `IR_out`=`NOP, `IR_valid`=0, buffer discarded, state FETCH, `Halted`=0. If `Br_taken`, `pc`=`Br_tgt`; otherwise `pc` unchanged. If a request is outstanding and `Imem_ack`=0 this cycle: `drop`=1, `stale_addr`=current `Imem_addr`. An ack in the flush cycle is discarded and needs no `drop`.
- `drop`=1: the next ack is discarded, `drop` clears, and `pc` does not advance. A new fetch from `pc` starts the following cycle.
- Stall, state FETCH, valid ack: capture into buffer, `pc`+=1, state HOLD (or HALTED if opcode `[31:26]`==`HALT, `pc` not advanced). Outputs hold.
- Stall otherwise: all outputs and state hold.
- Normal, HOLD: outputs ← buffer, `IR_valid`=1, state FETCH.
- Normal, FETCH, valid ack: outputs ← (`Imem_data`, `Imem_addr`), `IR_valid`=1, `pc`+=1. If opcode==`HALT: `pc` not advanced, state HALTED.
- Normal, FETCH, no ack: bubble (`IR_out`=`NOP, `IR_valid`=0).
- HALTED: no requests. Bubbles when not stalled. `Halted`=1. Exits only by reset or redirect/flush.
- `pc`+1 wraps modulo 2^(WIDTH-2).

## Timing
- Zero-wait memory: ack in cycle k → `IR_out` valid after edge ending k. Sustained rate is 1 instruction/cycle.
- N-cycle memory: N-1 bubbles per instruction.
- Redirect in cycle k with no outstanding fetch: request to `Br_tgt` in cycle k+1, earliest valid output after edge k+1.
- Redirect during an outstanding fetch: the target request is delayed until the stale ack retires.
- `Br_taken` and `IsStall` in the same cycle: redirect wins.
- Stall release from HOLD: buffered instruction is delivered on the first unstalled edge, with no memory access.
- Reset mid-fetch: a pending ack after reset is not expected; memory is reset together with this stage.

## Test plan
- Reset then zero-wait memory returning word = 0x1000_0000|addr: `PC_out` sequence 0,1,2,3 on consecutive cycles with `IR_valid`=1, and `IR_out` matching each address.
- 3-cycle memory latency: exactly 2 `NOP` bubbles (`IR_valid`=0) between successive valid instructions.
- Stall asserted for 4 cycles while an ack arrives: outputs frozen; buffered word at PC 5 appears on the first unstalled edge; no duplicate fetch of PC 5.
- `Br_taken`=1, `Br_tgt`=0x40 while a fetch of PC 7 is outstanding: that response is discarded; next valid output is `PC_out`=0x40.
- `HALT` at PC 9: `HALT` delivered valid, `Halted`=1, `Imem_req`=0 thereafter. `Br_taken` to 0x20 resumes fetch at 0x20 with `Halted`=0.
- `pc`=2^30−1 with `WIDTH`=32: next `PC_out` is 0.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory handshake between the fetch stage and instruction memory.
// The fetch stage is the master: it raises the request and address, memory answers with data and ack.
interface if_stage_if #(
    parameter int WIDTH = 32
);
    logic             Imem_req;
    logic [WIDTH-3:0] Imem_addr;
    logic [WIDTH-1:0] Imem_data;
    logic             Imem_ack;

    modport master (output Imem_req, Imem_addr, input  Imem_data, Imem_ack);
    modport slave  (input  Imem_req, Imem_addr, output Imem_data, Imem_ack);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake, feeds decode.
// A one-entry skid buffer catches a response that lands while decode is stalled.
//
//  state  | meaning
//  FETCH  | requesting imem[pc]; a valid ack is delivered or buffered
//  HOLD   | stalled with a buffered word, delivered on the first unstalled edge
//  HALTED | HALT seen; no requests until reset or redirect/flush
module if_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-3:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] NOP      = '0,
    parameter logic [5:0]       HALT_OP  = 6'h3F
) (
    input  logic             clk,
    input  logic             rst,
    if_stage_if.master       imem,
    output logic [WIDTH-1:0] IR_out,
    output logic [WIDTH-3:0] PC_out,
    output logic             IR_valid,
    input  logic             IsStall,
    input  logic             IsFlush,
    input  logic             Br_taken,
    input  logic [WIDTH-3:0] Br_tgt,
    output logic             Halted
);
    typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

    localparam logic [WIDTH-3:0] PC_ONE = {{(WIDTH-3){1'b0}}, 1'b1};

    state_t           state, n_state;
    logic [WIDTH-3:0] pc, n_pc;
    logic [WIDTH-1:0] n_ir;
    logic [WIDTH-3:0] n_pc_out;
    logic             n_valid;
    logic [WIDTH-1:0] buf_ir, n_buf_ir;
    logic [WIDTH-3:0] buf_pc, n_buf_pc;
    logic             buf_valid, n_buf_valid;
    logic             drop, n_drop;
    logic [WIDTH-3:0] stale_addr, n_stale_addr;

    logic             req;
    logic [WIDTH-3:0] addr;
    logic             ack_ok;
    logic             data_halt;
    logic             buf_halt;

    assign req            = (state == FETCH) || drop;
    assign addr           = drop ? stale_addr : pc;
    assign imem.Imem_req  = req;
    assign imem.Imem_addr = addr;
    // an ack only belongs to the current fetch when no stale response is still owed
    assign ack_ok         = imem.Imem_ack && req && !drop;
    assign data_halt      = (imem.Imem_data[WIDTH-1 -: 6] == HALT_OP);
    assign buf_halt       = (buf_ir[WIDTH-1 -: 6] == HALT_OP);
    assign Halted         = (state == HALTED);

    always_comb begin
        n_state      = state;
        n_pc         = pc;
        n_ir         = IR_out;
        n_pc_out     = PC_out;
        n_valid      = IR_valid;
        n_buf_ir     = buf_ir;
        n_buf_pc     = buf_pc;
        n_buf_valid  = buf_valid;
        n_drop       = drop;
        n_stale_addr = stale_addr;

        if (IsFlush || Br_taken) begin
            n_ir        = NOP;
            n_valid     = 1'b0;
            n_buf_valid = 1'b0;
            n_state     = FETCH;
            if (Br_taken)
                n_pc = Br_tgt;
            if (req && !imem.Imem_ack) begin
                n_drop       = 1'b1;
                n_stale_addr = addr;
            end else begin
                n_drop = 1'b0;
            end
        end else begin
            if (drop && imem.Imem_ack)
                n_drop = 1'b0;
            if (IsStall) begin
                if (state == FETCH && ack_ok) begin
                    n_buf_ir    = imem.Imem_data;
                    n_buf_pc    = addr;
                    n_buf_valid = 1'b1;
                    if (data_halt) begin
                        n_state = HALTED;
                    end else begin
                        n_pc    = pc + PC_ONE;
                        n_state = HOLD;
                    end
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (ack_ok) begin
                            n_ir     = imem.Imem_data;
                            n_pc_out = addr;
                            n_valid  = 1'b1;
                            if (data_halt)
                                n_state = HALTED;
                            else
                                n_pc = pc + PC_ONE;
                        end else begin
                            n_ir    = NOP;
                            n_valid = 1'b0;
                        end
                    end
                    HOLD: begin
                        n_ir        = buf_ir;
                        n_pc_out    = buf_pc;
                        n_valid     = 1'b1;
                        n_buf_valid = 1'b0;
                        n_state     = FETCH;
                    end
                    HALTED: begin
                        // a HALT captured under stall still has to reach decode once
                        if (buf_valid && buf_halt) begin
                            n_ir        = buf_ir;
                            n_pc_out    = buf_pc;
                            n_valid     = 1'b1;
                            n_buf_valid = 1'b0;
                        end else begin
                            n_ir    = NOP;
                            n_valid = 1'b0;
                        end
                    end
                    default: n_state = FETCH;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            IR_out     <= NOP;
            PC_out     <= '0;
            IR_valid   <= 1'b0;
            buf_ir     <= NOP;
            buf_pc     <= '0;
            buf_valid  <= 1'b0;
            drop       <= 1'b0;
            stale_addr <= '0;
        end else begin
            state      <= n_state;
            pc         <= n_pc;
            IR_out     <= n_ir;
            PC_out     <= n_pc_out;
            IR_valid   <= n_valid;
            buf_ir     <= n_buf_ir;
            buf_pc     <= n_buf_pc;
            buf_valid  <= n_buf_valid;
            drop       <= n_drop;
            stale_addr <= n_stale_addr;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: behavioural instruction memory with configurable latency,
// expected deliveries queued per scenario and compared as the stage presents them.
module tb_if_stage;
    localparam int         W       = 32;
    localparam logic [5:0] HALT_OP = 6'h3F;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] IR_out;
    logic [W-3:0] PC_out;
    logic         IR_valid;
    logic         IsStall, IsFlush, Br_taken;
    logic [W-3:0] Br_tgt;
    logic         Halted;

    if_stage_if #(.WIDTH(W)) imem ();

    if_stage #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .imem     (imem),
        .IR_out   (IR_out),
        .PC_out   (PC_out),
        .IR_valid (IR_valid),
        .IsStall  (IsStall),
        .IsFlush  (IsFlush),
        .Br_taken (Br_taken),
        .Br_tgt   (Br_tgt),
        .Halted   (Halted)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int           lat        = 1;
    bit           mem_en     = 1'b0;
    int           cnt        = 0;
    logic [W-3:0] halt_addr  = 30'h3FFF_FFF0;
    logic [W-3:0] watch_addr = 30'h3FFF_FFF1;
    int           watch_acks = 0;

    logic [W-3:0] exp_pc_q[$];
    logic [W-1:0] exp_ir_q[$];

    function automatic logic [W-1:0] mem_word(input logic [W-3:0] a);
        if (a == halt_addr)
            return {HALT_OP, 26'h0} | {2'b00, a};
        return 32'h1000_0000 | {2'b00, a};
    endfunction

    // memory model: ack after `lat` cycles of continuous request (lat=1 is zero-wait)
    initial begin
        imem.Imem_ack  = 1'b0;
        imem.Imem_data = '0;
        forever begin
            @(negedge clk);
            if (mem_en && imem.Imem_req) begin
                cnt++;
                if (cnt >= lat) begin
                    imem.Imem_ack  = 1'b1;
                    imem.Imem_data = mem_word(imem.Imem_addr);
                    cnt = 0;
                    if (imem.Imem_addr == watch_addr)
                        watch_acks++;
                end else begin
                    imem.Imem_ack = 1'b0;
                end
            end else begin
                imem.Imem_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [W-3:0] a);
        exp_pc_q.push_back(a);
        exp_ir_q.push_back(mem_word(a));
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_en = 1'b0;
        IsStall = 1'b0; IsFlush = 1'b0; Br_taken = 1'b0; Br_tgt = '0;
        exp_pc_q.delete(); exp_ir_q.delete();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        lat = 1; mem_en = 1'b1;
        repeat (3) tick();
        rst = 1'b1; mem_en = 1'b0;
        tick();
        checks++;
        if (IR_valid !== 1'b0 || IR_out !== 32'h0 || PC_out !== 30'h0 || Halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b ir=%h pc=%h halted=%b, want 0 0 0 0",
                     IR_valid, IR_out, PC_out, Halted);
        end
        checks++;
        if (imem.Imem_req !== 1'b1 || imem.Imem_addr !== 30'h0) begin
            errors++;
            $display("FAIL reset_fetch: got req=%b addr=%h, want req=1 addr=0", imem.Imem_req, imem.Imem_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        do_reset();
        lat = 1; mem_en = 1'b1;
        for (int i = 0; i < 4; i++) push_exp(i[W-3:0]);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (IR_valid !== 1'b1 || PC_out !== exp_pc_q[0] || IR_out !== exp_ir_q[0]) begin
                errors++;
                $display("FAIL zero_wait[%0d]: got valid=%b pc=%h ir=%h, want valid=1 pc=%h ir=%h",
                         i, IR_valid, PC_out, IR_out, exp_pc_q[0], exp_ir_q[0]);
            end
            void'(exp_pc_q.pop_front()); void'(exp_ir_q.pop_front());
        end
    endtask

    task automatic test_latency();
        int gap = 0;
        bit first = 1'b1;
        int guard = 0;
        do_reset();
        lat = 3; mem_en = 1'b1;
        for (int i = 0; i < 4; i++) push_exp(i[W-3:0]);
        while (exp_pc_q.size() > 0 && guard < 40) begin
            tick(); guard++;
            if (IR_valid) begin
                checks++;
                if (PC_out !== exp_pc_q[0] || IR_out !== exp_ir_q[0]) begin
                    errors++;
                    $display("FAIL latency_data: got pc=%h ir=%h, want pc=%h ir=%h",
                             PC_out, IR_out, exp_pc_q[0], exp_ir_q[0]);
                end
                if (!first) begin
                    checks++;
                    if (gap != 2) begin
                        errors++;
                        $display("FAIL latency_bubbles: got %0d bubbles, want 2", gap);
                    end
                end
                void'(exp_pc_q.pop_front()); void'(exp_ir_q.pop_front());
                first = 1'b0; gap = 0;
            end else begin
                gap++;
            end
        end
        checks++;
        if (exp_pc_q.size() != 0) begin
            errors++;
            $display("FAIL latency_timeout: got %0d pending, want 0", exp_pc_q.size());
        end
    endtask

    task automatic test_stall();
        int guard = 0;
        do_reset();
        lat = 1; mem_en = 1'b1;
        watch_addr = 30'd5; watch_acks = 0;
        for (int i = 0; i < 5; i++) push_exp(i[W-3:0]);
        while (exp_pc_q.size() > 0 && guard < 20) begin
            tick(); guard++;
            if (IR_valid) begin
                checks++;
                if (PC_out !== exp_pc_q[0] || IR_out !== exp_ir_q[0]) begin
                    errors++;
                    $display("FAIL stall_pre: got pc=%h ir=%h, want pc=%h ir=%h",
                             PC_out, IR_out, exp_pc_q[0], exp_ir_q[0]);
                end
                void'(exp_pc_q.pop_front()); void'(exp_ir_q.pop_front());
            end
        end
        checks++;
        if (imem.Imem_req !== 1'b1 || imem.Imem_addr !== 30'd5) begin
            errors++;
            $display("FAIL stall_setup: got req=%b addr=%h, want req=1 addr=5", imem.Imem_req, imem.Imem_addr);
        end
        IsStall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (IR_valid !== 1'b1 || PC_out !== 30'd4 || IR_out !== mem_word(30'd4)) begin
                errors++;
                $display("FAIL stall_frozen[%0d]: got valid=%b pc=%h ir=%h, want valid=1 pc=4 ir=%h",
                         i, IR_valid, PC_out, IR_out, mem_word(30'd4));
            end
        end
        checks++;
        if (imem.Imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold_req: got req=%b, want 0", imem.Imem_req);
        end
        IsStall = 1'b0;
        push_exp(30'd5); push_exp(30'd6);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (IR_valid !== 1'b1 || PC_out !== exp_pc_q[0] || IR_out !== exp_ir_q[0]) begin
                errors++;
                $display("FAIL stall_release[%0d]: got valid=%b pc=%h ir=%h, want valid=1 pc=%h ir=%h",
                         i, IR_valid, PC_out, IR_out, exp_pc_q[0], exp_ir_q[0]);
            end
            void'(exp_pc_q.pop_front()); void'(exp_ir_q.pop_front());
        end
        checks++;
        if (watch_acks != 1) begin
            errors++;
            $display("FAIL stall_no_refetch: got %0d fetches of pc 5, want 1", watch_acks);
        end
    endtask

    task automatic test_branch();
        int guard = 0;
        do_reset();
        lat = 3; mem_en = 1'b1;
        while (!(imem.Imem_req === 1'b1 && imem.Imem_addr === 30'd7) && guard < 60) begin
            tick(); guard++;
        end
        checks++;
        if (imem.Imem_addr !== 30'd7) begin
            errors++;
            $display("FAIL branch_setup: got addr=%h, want 7", imem.Imem_addr);
        end
        Br_taken = 1'b1; Br_tgt = 30'h40;
        tick();
        Br_taken = 1'b0;
        checks++;
        if (IR_valid !== 1'b0 || imem.Imem_req !== 1'b1 || imem.Imem_addr !== 30'd7) begin
            errors++;
            $display("FAIL branch_stale: got valid=%b req=%b addr=%h, want valid=0 req=1 addr=7",
                     IR_valid, imem.Imem_req, imem.Imem_addr);
        end
        push_exp(30'h40);
        guard = 0;
        while (exp_pc_q.size() > 0 && guard < 20) begin
            tick(); guard++;
            if (IR_valid) begin
                checks++;
                if (PC_out !== exp_pc_q[0] || IR_out !== exp_ir_q[0]) begin
                    errors++;
                    $display("FAIL branch_target: got pc=%h ir=%h, want pc=%h ir=%h",
                             PC_out, IR_out, exp_pc_q[0], exp_ir_q[0]);
                end
                void'(exp_pc_q.pop_front()); void'(exp_ir_q.pop_front());
            end
        end
        checks++;
        if (exp_pc_q.size() != 0) begin
            errors++;
            $display("FAIL branch_timeout: got %0d pending, want 0", exp_pc_q.size());
        end
    endtask

    task automatic test_halt();
        int guard = 0;
        do_reset();
        halt_addr = 30'd9;
        lat = 1; mem_en = 1'b1;
        for (int i = 0; i < 10; i++) push_exp(i[W-3:0]);
        while (exp_pc_q.size() > 0 && guard < 30) begin
            tick(); guard++;
            if (IR_valid) begin
                checks++;
                if (PC_out !== exp_pc_q[0] || IR_out !== exp_ir_q[0]) begin
                    errors++;
                    $display("FAIL halt_stream: got pc=%h ir=%h, want pc=%h ir=%h",
                             PC_out, IR_out, exp_pc_q[0], exp_ir_q[0]);
                end
                void'(exp_pc_q.pop_front()); void'(exp_ir_q.pop_front());
            end
        end
        checks++;
        if (Halted !== 1'b1 || imem.Imem_req !== 1'b0 || exp_pc_q.size() != 0) begin
            errors++;
            $display("FAIL halt_enter: got halted=%b req=%b pending=%0d, want 1 0 0",
                     Halted, imem.Imem_req, exp_pc_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (imem.Imem_req !== 1'b0 || IR_valid !== 1'b0 || Halted !== 1'b1) begin
                errors++;
                $display("FAIL halt_idle[%0d]: got req=%b valid=%b halted=%b, want 0 0 1",
                         i, imem.Imem_req, IR_valid, Halted);
            end
        end
        Br_taken = 1'b1; Br_tgt = 30'h20;
        tick();
        Br_taken = 1'b0;
        checks++;
        if (Halted !== 1'b0 || imem.Imem_req !== 1'b1 || imem.Imem_addr !== 30'h20 || IR_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_redirect: got halted=%b req=%b addr=%h valid=%b, want 0 1 20 0",
                     Halted, imem.Imem_req, imem.Imem_addr, IR_valid);
        end
        tick();
        checks++;
        if (IR_valid !== 1'b1 || PC_out !== 30'h20 || IR_out !== mem_word(30'h20)) begin
            errors++;
            $display("FAIL halt_resume: got valid=%b pc=%h ir=%h, want valid=1 pc=20 ir=%h",
                     IR_valid, PC_out, IR_out, mem_word(30'h20));
        end
        halt_addr = 30'h3FFF_FFF0;
    endtask

    task automatic test_wrap_stall_redirect();
        do_reset();
        lat = 1; mem_en = 1'b1;
        IsStall = 1'b1; Br_taken = 1'b1; Br_tgt = 30'h3FFF_FFFF;
        tick();
        IsStall = 1'b0; Br_taken = 1'b0;
        checks++;
        if (IR_valid !== 1'b0 || imem.Imem_req !== 1'b1 || imem.Imem_addr !== 30'h3FFF_FFFF) begin
            errors++;
            $display("FAIL redirect_over_stall: got valid=%b req=%b addr=%h, want 0 1 3fffffff",
                     IR_valid, imem.Imem_req, imem.Imem_addr);
        end
        push_exp(30'h3FFF_FFFF); push_exp(30'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (IR_valid !== 1'b1 || PC_out !== exp_pc_q[0] || IR_out !== exp_ir_q[0]) begin
                errors++;
                $display("FAIL pc_wrap[%0d]: got valid=%b pc=%h ir=%h, want valid=1 pc=%h ir=%h",
                         i, IR_valid, PC_out, IR_out, exp_pc_q[0], exp_ir_q[0]);
            end
            void'(exp_pc_q.pop_front()); void'(exp_ir_q.pop_front());
        end
    endtask

    initial begin
        rst = 1'b1; IsStall = 1'b0; IsFlush = 1'b0; Br_taken = 1'b0; Br_tgt = '0;
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall();
        test_branch();
        test_halt();
        test_wrap_stall_redirect();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule
